// File: rtl/pwm_synth_multi.sv
// pwm_synth_multi: multi-voice PWM tone synthesiser.
// Each voice runs its own phase accumulator and waveform generator.
// The voice samples are volume-scaled, summed and averaged into one
// 8-bit mix sample. That sample sets the duty of a single PWM carrier,
// and the duty is updated only at carrier period boundaries.
module pwm_synth_multi #(
    parameter int CHANNELS = 2,
    parameter int DIV_BITS = 12,
    parameter int PWM_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          enable,
    input  logic [CHANNELS*DIV_BITS-1:0] divider,
    input  logic [CHANNELS*2-1:0]        mode,
    input  logic [CHANNELS*4-1:0]        volume,
    output logic                         pwm,
    output logic                         period_start
);

    typedef enum logic [1:0] {
        WAVE_SINE     = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_SAW      = 2'd2,
        WAVE_TRIANGLE = 2'd3
    } waveMode_e;

    localparam int LOG2CH = $clog2(CHANNELS);
    localparam int SUM_W  = 8 + LOG2CH;
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [7:0]          phase_q [CHANNELS];
    logic [7:0]          phase_d [CHANNELS];
    logic [DIV_BITS-1:0] count_q [CHANNELS];
    logic [DIV_BITS-1:0] count_d [CHANNELS];
    logic [7:0]          wave    [CHANNELS];
    logic [7:0]          scaled  [CHANNELS];
    logic [SUM_W-1:0]    mixSum;
    logic [7:0]          mix_d;
    logic [7:0]          mix_q;
    logic [PWM_BITS-1:0] carrier_d;
    logic [PWM_BITS-1:0] carrier_q;
    logic [PWM_BITS-1:0] duty_d;
    logic [PWM_BITS-1:0] duty_q;
    logic                pwm_d;
    logic                pwm_q;
    logic                loadDuty;

    // First quadrant of round(127*sin(2*pi*k/256)) for k = 0..64; the
    // rest of the cycle is rebuilt by mirroring and negation.
    function automatic logic [6:0] sineQuarter(input logic [6:0] idx);
        logic [6:0] mag;
        case (idx)
            7'd0:    mag = 7'd0;
            7'd1:    mag = 7'd3;
            7'd2:    mag = 7'd6;
            7'd3:    mag = 7'd9;
            7'd4:    mag = 7'd12;
            7'd5:    mag = 7'd16;
            7'd6:    mag = 7'd19;
            7'd7:    mag = 7'd22;
            7'd8:    mag = 7'd25;
            7'd9:    mag = 7'd28;
            7'd10:   mag = 7'd31;
            7'd11:   mag = 7'd34;
            7'd12:   mag = 7'd37;
            7'd13:   mag = 7'd40;
            7'd14:   mag = 7'd43;
            7'd15:   mag = 7'd46;
            7'd16:   mag = 7'd49;
            7'd17:   mag = 7'd51;
            7'd18:   mag = 7'd54;
            7'd19:   mag = 7'd57;
            7'd20:   mag = 7'd60;
            7'd21:   mag = 7'd63;
            7'd22:   mag = 7'd65;
            7'd23:   mag = 7'd68;
            7'd24:   mag = 7'd71;
            7'd25:   mag = 7'd73;
            7'd26:   mag = 7'd76;
            7'd27:   mag = 7'd78;
            7'd28:   mag = 7'd81;
            7'd29:   mag = 7'd83;
            7'd30:   mag = 7'd85;
            7'd31:   mag = 7'd88;
            7'd32:   mag = 7'd90;
            7'd33:   mag = 7'd92;
            7'd34:   mag = 7'd94;
            7'd35:   mag = 7'd96;
            7'd36:   mag = 7'd98;
            7'd37:   mag = 7'd100;
            7'd38:   mag = 7'd102;
            7'd39:   mag = 7'd104;
            7'd40:   mag = 7'd106;
            7'd41:   mag = 7'd107;
            7'd42:   mag = 7'd109;
            7'd43:   mag = 7'd111;
            7'd44:   mag = 7'd112;
            7'd45:   mag = 7'd113;
            7'd46:   mag = 7'd115;
            7'd47:   mag = 7'd116;
            7'd48:   mag = 7'd117;
            7'd49:   mag = 7'd118;
            7'd50:   mag = 7'd120;
            7'd51:   mag = 7'd121;
            7'd52:   mag = 7'd122;
            7'd53:   mag = 7'd122;
            7'd54:   mag = 7'd123;
            7'd55:   mag = 7'd124;
            7'd56:   mag = 7'd125;
            7'd57:   mag = 7'd125;
            7'd58:   mag = 7'd126;
            7'd59:   mag = 7'd126;
            7'd60:   mag = 7'd126;
            default: mag = 7'd127;
        endcase
        return mag;
    endfunction

    // Unsigned 8-bit waveform value for a given phase. Sine mirrors the
    // quarter table about p=64 and flips sign in the second half-cycle.
    function automatic logic [7:0] waveValue(input logic [7:0] p, input waveMode_e sel);
        logic [6:0] q;
        logic [6:0] idx;
        logic [7:0] mag;
        logic [7:0] w;
        q   = p[6:0];
        idx = (q <= 7'd64) ? q : (7'd0 - q);
        mag = {1'b0, sineQuarter(idx)};
        case (sel)
            WAVE_SINE:   w = p[7] ? (8'd128 - mag) : (8'd128 + mag);
            WAVE_SQUARE: w = p[7] ? 8'd0 : 8'd255;
            WAVE_SAW:    w = p;
            default:     w = p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
        endcase
        return w;
    endfunction

    // Per-voice phase stepping: a reload of the divider each time the
    // down-counter expires, so a new divider only lands at the next reload.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            phase_d[n] = phase_q[n];
            count_d[n] = count_q[n];
            if (!enable[n]) begin
                phase_d[n] = '0;
                count_d[n] = '0;
            end else if (count_q[n] == '0) begin
                phase_d[n] = phase_q[n] + 8'd1;
                count_d[n] = divider[n*DIV_BITS +: DIV_BITS];
            end else begin
                count_d[n] = count_q[n] - DIV_BITS'(1);
            end
        end
    end

    // Waveform lookup and volume scaling; a disabled voice is forced silent
    // because its reset phase would otherwise still produce a sine midpoint.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            wave[n]   = waveValue(phase_q[n], waveMode_e'(mode[n*2 +: 2]));
            scaled[n] = enable[n]
                      ? 8'(({4'd0, wave[n]} * {8'd0, volume[n*4 +: 4]}) >> 4)
                      : 8'd0;
        end
    end

    // Exact sum of all voices, then divide by the voice count so the mix
    // always fits in 8 bits.
    always_comb begin
        mixSum = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            mixSum = mixSum + SUM_W'(scaled[n]);
        end
        mix_d = 8'(mixSum >> LOG2CH);
    end

    // Carrier counter, boundary-only duty load and comparator.
    always_comb begin
        loadDuty  = (carrier_q == CNT_LAST);
        carrier_d = carrier_q + PWM_BITS'(1);
        duty_d    = loadDuty ? (PWM_BITS'(mix_q) << (PWM_BITS - 8)) : duty_q;
        pwm_d     = (carrier_q < duty_q);
    end

    // All state registers; reset wins over everything and aborts a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < CHANNELS; n++) begin
                phase_q[n] <= '0;
                count_q[n] <= '0;
            end
            mix_q     <= '0;
            carrier_q <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                phase_q[n] <= phase_d[n];
                count_q[n] <= count_d[n];
            end
            mix_q     <= mix_d;
            carrier_q <= carrier_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = loadDuty;

endmodule

// File: tb/tb_pwm_synth_multi.sv
// Testbench for pwm_synth_multi: a one-voice and a two-voice instance
// share clock, reset and stimulus; high time per carrier period is
// compared against hand-computed values.
module tb_pwm_synth_multi;

    localparam logic [1:0] SINE = 2'd0;
    localparam logic [1:0] SQ   = 2'd1;
    localparam logic [1:0] SAW  = 2'd2;
    localparam logic [1:0] TRI  = 2'd3;
    localparam logic [23:0] D255 = {12'd255, 12'd255};
    localparam logic [23:0] D3   = {12'd3, 12'd3};

    typedef struct packed {
        logic        two;
        logic [1:0]  en;
        logic [23:0] div;
        logic [3:0]  mode;
        logic [7:0]  vol;
        int          period;
        int          expHigh;
    } vec_t;

    localparam int NV = 21;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  enable;
    logic [23:0] divider;
    logic [3:0]  mode;
    logic [7:0]  volume;
    logic        pwmOne;
    logic        psOne;
    logic        pwmTwo;
    logic        psTwo;

    int compared   = 0;
    int mismatched = 0;
    int high;
    int highB;
    int psc;
    int psl;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    pwm_synth_multi #(.CHANNELS(1), .DIV_BITS(12), .PWM_BITS(8)) dutOne (
        .clk(clk), .rst(rst), .enable(enable[0:0]), .divider(divider[11:0]),
        .mode(mode[1:0]), .volume(volume[3:0]), .pwm(pwmOne), .period_start(psOne)
    );

    pwm_synth_multi #(.CHANNELS(2), .DIV_BITS(12), .PWM_BITS(8)) dutTwo (
        .clk(clk), .rst(rst), .enable(enable), .divider(divider),
        .mode(mode), .volume(volume), .pwm(pwmTwo), .period_start(psTwo)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive a configuration while holding reset, then release; the last
    // sample taken inside this task is the first post-reset state.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst     = 1'b1;
        enable  = v.en;
        divider = v.div;
        mode    = v.mode;
        volume  = v.vol;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Sample n cycles of the selected instance on falling edges.
    task automatic countSamples(input logic two, input int n, output int hi, output int pCount, output int pLast);
        hi     = 0;
        pCount = 0;
        pLast  = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if ((two ? pwmTwo : pwmOne) === 1'b1) hi++;
            if ((two ? psTwo : psOne) === 1'b1) begin
                pCount++;
                pLast = i + 1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, 2'b01, D255, {SQ, SQ},     8'hFF, 1, 239};
        vecs[1]  = '{1'b0, 2'b01, D255, {SQ, SQ},     8'hFF, 3, 239};
        vecs[2]  = '{1'b0, 2'b01, D255, {SAW, SAW},   8'hFF, 1, 0};
        vecs[3]  = '{1'b0, 2'b01, D255, {SAW, SAW},   8'hFF, 3, 2};
        vecs[4]  = '{1'b0, 2'b01, D255, {SAW, SAW},   8'hFF, 5, 4};
        vecs[5]  = '{1'b0, 2'b01, D255, {TRI, TRI},   8'hFF, 4, 7};
        vecs[6]  = '{1'b0, 2'b01, D3,   {SAW, SAW},   8'h88, 1, 32};
        vecs[7]  = '{1'b0, 2'b01, D3,   {SAW, SAW},   8'h88, 2, 64};
        vecs[8]  = '{1'b0, 2'b01, D3,   {SINE, SINE}, 8'hFF, 1, 239};
        vecs[9]  = '{1'b0, 2'b01, D3,   {SINE, SINE}, 8'hFF, 2, 120};
        vecs[10] = '{1'b0, 2'b01, D3,   {SINE, SINE}, 8'hFF, 3, 0};
        vecs[11] = '{1'b0, 2'b01, D3,   {SINE, SINE}, 8'hFF, 4, 120};
        vecs[12] = '{1'b0, 2'b01, D3,   {TRI, TRI},   8'hFF, 2, 238};
        vecs[13] = '{1'b0, 2'b01, D255, {SQ, SQ},     8'h00, 1, 0};
        vecs[14] = '{1'b0, 2'b00, D255, {SQ, SQ},     8'hFF, 1, 0};
        vecs[15] = '{1'b1, 2'b01, D255, {SQ, SQ},     8'hFF, 1, 119};
        vecs[16] = '{1'b1, 2'b11, D255, {SQ, SQ},     8'hFF, 1, 239};
        vecs[17] = '{1'b1, 2'b11, D255, {SQ, SQ},     8'h0F, 1, 119};
        vecs[18] = '{1'b1, 2'b11, D3,   {SINE, SAW},  8'hFF, 1, 149};
        vecs[19] = '{1'b1, 2'b11, D3,   {SQ, TRI},    8'h8F, 1, 123};
        vecs[20] = '{1'b1, 2'b11, {12'd3, 12'd255}, {SAW, SAW}, 8'hFF, 1, 30};

        // Reset held with everything enabled at full volume.
        rst     = 1'b1;
        enable  = 2'b11;
        divider = D255;
        mode    = {SQ, SQ};
        volume  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("reset cycle %0d outputs", c), {28'd0, pwmOne, psOne, pwmTwo, psTwo}, 32'd0);
        end
        rst = 1'b0;
        countSamples(1'b1, 256, high, psc, psl);
        checkOutput("first period high", high, 0);
        checkOutput("first period pulse count", psc, 1);
        checkOutput("first period pulse cycle", psl, 255);
        countSamples(1'b1, 256, high, psc, psl);
        checkOutput("second period high", high, 239);

        // Directed vector table.
        for (int k = 0; k < NV; k++) begin
            applyStimulus(vecs[k]);
            for (int w = 0; w <= vecs[k].period; w++) begin
                countSamples(vecs[k].two, 256, high, psc, psl);
                if (w == 0) checkOutput($sformatf("vec%0d period0 high", k), high, 0);
            end
            checkOutput($sformatf("vec%0d period%0d high", k, vecs[k].period), high, vecs[k].expHigh);
        end

        // Divider 255 -> 0 part-way through a count: the running count
        // must finish, after which the phase steps every cycle.
        applyStimulus('{1'b0, 2'b01, D255, {SAW, SAW}, 8'hFF, 0, 0});
        countSamples(1'b0, 100, high, psc, psl);
        divider = 24'd0;
        countSamples(1'b0, 156, highB, psc, psl);
        checkOutput("divchange period0 high", high + highB, 0);
        countSamples(1'b0, 256, high, psc, psl);
        checkOutput("divchange period1 high", high, 0);
        countSamples(1'b0, 256, high, psc, psl);
        checkOutput("divchange period2 high", high, 239);

        // Reset asserted in the middle of a high pulse.
        applyStimulus('{1'b0, 2'b01, D3, {SAW, SAW}, 8'hFF, 0, 0});
        countSamples(1'b0, 256, high, psc, psl);
        countSamples(1'b0, 30, high, psc, psl);
        checkOutput("pre-abort high count", high, 30);
        checkOutput("pre-abort pwm", {31'd0, pwmOne}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort pwm", {31'd0, pwmOne}, 32'd0);
        checkOutput("abort period_start", {31'd0, psOne}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        countSamples(1'b0, 256, high, psc, psl);
        checkOutput("post-abort period0 high", high, 0);
        checkOutput("post-abort pulse cycle", psl, 255);
        countSamples(1'b0, 256, high, psc, psl);
        checkOutput("post-abort period1 high", high, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
